// File: rtl/pc_seq_ctrl_if.sv
// Bus bundle for the next-PC sequencer: hazard/branch/jump inputs and PC/flush outputs.
// Interrupt signals exist only when PC_SEQ_IRQ_EN is defined.
interface pc_seq_ctrl_if #(
    parameter int PC_W = 16
);
    logic            stall;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            jmp;
    logic [PC_W-1:0] jmp_target;
    logic            halt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] npc;
    logic            if_valid;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic [1:0]      state;
`ifdef PC_SEQ_IRQ_EN
    logic            irq;
    logic            eret;
    logic            irq_ack;
    logic [PC_W-1:0] epc;
`endif

    modport master (
        output stall, br_taken, br_target, jmp, jmp_target, halt,
`ifdef PC_SEQ_IRQ_EN
        output irq, eret,
        input  irq_ack, epc,
`endif
        input  pc, npc, if_valid, flush_if_id, flush_id_ex, state
    );

    modport slave (
        input  stall, br_taken, br_target, jmp, jmp_target, halt,
`ifdef PC_SEQ_IRQ_EN
        input  irq, eret,
        output irq_ack, epc,
`endif
        output pc, npc, if_valid, flush_if_id, flush_id_ex, state
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer for the IF stage: picks the fetch address, drives latch flushes and
// tracks boot/run/halt. Define PC_SEQ_IRQ_EN to add interrupt entry/return (irq, eret, epc).
//
// state | meaning
// BOOT  | one settling cycle after reset, PC held, fetch slot invalid
// RUN   | normal fetch: branch > (eret) > jump > stall > (irq) > halt > sequential
// HALT  | PC frozen, fetch invalid; left only by reset (or irq when enabled)
module pc_seq_ctrl #(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_VEC = '0
`ifdef PC_SEQ_IRQ_EN
    ,
    parameter logic [PC_W-1:0] IRQ_VEC   = PC_W'(16'h0010)
`endif
) (
    input logic          clk,
    input logic          reset,
    pc_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            flush_if_id, flush_id_ex;

`ifdef PC_SEQ_IRQ_EN
    logic [PC_W-1:0] epc_q, epc_d;
    logic            in_hdl_q, in_hdl_d;
    logic            irq_ack_q, irq_ack_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VEC;
`ifdef PC_SEQ_IRQ_EN
            epc_q     <= '0;
            in_hdl_q  <= 1'b0;
            irq_ack_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
`ifdef PC_SEQ_IRQ_EN
            epc_q     <= epc_d;
            in_hdl_q  <= in_hdl_d;
            irq_ack_q <= irq_ack_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
`ifdef PC_SEQ_IRQ_EN
        epc_d       = epc_q;
        in_hdl_d    = in_hdl_q;
        irq_ack_d   = 1'b0;
`endif
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                // A resolved branch beats everything, including a stall.
                if (bus.br_taken) begin
                    pc_d        = bus.br_target;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
`ifdef PC_SEQ_IRQ_EN
                end else if (bus.eret && !bus.stall) begin
                    pc_d        = epc_q;
                    flush_if_id = 1'b1;
                    in_hdl_d    = 1'b0;
`endif
                end else if (bus.jmp && !bus.stall) begin
                    pc_d        = bus.jmp_target;
                    flush_if_id = 1'b1;
                end else if (bus.stall) begin
                    pc_d = pc_q;
`ifdef PC_SEQ_IRQ_EN
                end else if (bus.irq && !in_hdl_q) begin
                    epc_d       = pc_q;
                    pc_d        = IRQ_VEC;
                    flush_if_id = 1'b1;
                    in_hdl_d    = 1'b1;
                    irq_ack_d   = 1'b1;
`endif
                end else if (bus.halt) begin
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            HALT: begin
`ifdef PC_SEQ_IRQ_EN
                if (bus.irq && !in_hdl_q) begin
                    epc_d       = pc_q;
                    pc_d        = IRQ_VEC;
                    flush_if_id = 1'b1;
                    in_hdl_d    = 1'b1;
                    irq_ack_d   = 1'b1;
                    state_d     = RUN;
                end
`endif
            end
            default: state_d = BOOT;
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.npc         = pc_q + PC_W'(1);
    assign bus.if_valid    = (state_q == RUN);
    assign bus.flush_if_id = flush_if_id;
    assign bus.flush_id_ex = flush_id_ex;
    assign bus.state       = state_q;
`ifdef PC_SEQ_IRQ_EN
    assign bus.irq_ack     = irq_ack_q;
    assign bus.epc         = epc_q;
`endif
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: stimulus pushes model expectations, a negedge monitor
// pops and compares. Interrupt checks are compiled in only with PC_SEQ_IRQ_EN.
module tb_pc_seq_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    pc_seq_ctrl_if #(.PC_W(16)) bus ();

    pc_seq_ctrl #(.PC_W(16), .RESET_VEC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] npc;
        logic        iv;
        logic        fi;
        logic        fe;
        logic [1:0]  st;
        logic        ack;
        logic [15:0] epc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

`ifdef PC_SEQ_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam logic [15:0] IRQ_ADDR = 16'h0010;

    // Reference model: architectural PC, mode (0 boot, 1 run, 2 halt), interrupt context.
    logic [15:0] m_pc, m_epc;
    int          m_mode;
    logic        m_inh, m_ack;

    task automatic model_reset();
        m_pc = 16'h0000; m_epc = 16'h0000; m_mode = 0; m_inh = 1'b0; m_ack = 1'b0;
        q.delete();
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            chk("pc", bus.pc, e.pc);
            chk("npc", bus.npc, e.npc);
            chk("if_valid", {15'd0, bus.if_valid}, {15'd0, e.iv});
            chk("flush_if_id", {15'd0, bus.flush_if_id}, {15'd0, e.fi});
            chk("flush_id_ex", {15'd0, bus.flush_id_ex}, {15'd0, e.fe});
            chk("state", {14'd0, bus.state}, {14'd0, e.st});
`ifdef PC_SEQ_IRQ_EN
            chk("irq_ack", {15'd0, bus.irq_ack}, {15'd0, e.ack});
            chk("epc", bus.epc, e.epc);
`endif
        end
    end

    // Drive one cycle's inputs, record what the outputs must be, then advance the model.
    task automatic step(input logic s, input logic bt, input logic [15:0] btg,
                        input logic j, input logic [15:0] jt, input logic h,
                        input logic ir, input logic er);
        exp_t e;
        logic irq_go;
        bus.stall = s; bus.br_taken = bt; bus.br_target = btg;
        bus.jmp = j; bus.jmp_target = jt; bus.halt = h;
`ifdef PC_SEQ_IRQ_EN
        bus.irq = ir; bus.eret = er;
`endif
        e.pc = m_pc; e.npc = m_pc + 16'd1; e.iv = (m_mode == 1);
        e.st = 2'(m_mode); e.ack = m_ack; e.epc = m_epc; e.fi = 1'b0; e.fe = 1'b0;
        m_ack = 1'b0;
        irq_go = IRQ_ON && ir && !m_inh;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            if (irq_go) begin
                m_epc = m_pc; m_pc = IRQ_ADDR; e.fi = 1'b1; m_inh = 1'b1; m_ack = 1'b1; m_mode = 1;
            end
        end else if (bt) begin
            m_pc = btg; e.fi = 1'b1; e.fe = 1'b1;
        end else if (IRQ_ON && er && !s) begin
            m_pc = m_epc; e.fi = 1'b1; m_inh = 1'b0;
        end else if (j && !s) begin
            m_pc = jt; e.fi = 1'b1;
        end else if (!s) begin
            if (irq_go) begin
                m_epc = m_pc; m_pc = IRQ_ADDR; e.fi = 1'b1; m_inh = 1'b1; m_ack = 1'b1;
            end else if (h) begin
                m_mode = 2;
            end else begin
                m_pc = 16'((32'(m_pc) + 1) % 65536);
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 16'h0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.stall = 0; bus.br_taken = 0; bus.br_target = '0;
        bus.jmp = 0; bus.jmp_target = '0; bus.halt = 0;
`ifdef PC_SEQ_IRQ_EN
        bus.irq = 0; bus.eret = 0;
`endif
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int halt_cnt;
        do_reset();
        // Boot then free run: 0000(BOOT) 0000 0001 0002
        idle(4);
        while (m_pc != 16'h0005) idle(1);
        step(1, 1, 16'h0040, 1, 16'h0200, 0, 0, 0);
        step(0, 1, 16'h0010, 0, 16'h0, 0, 0, 0);
        step(1, 0, 16'h0, 1, 16'h0100, 0, 0, 0);
        step(1, 0, 16'h0, 1, 16'h0100, 0, 0, 0);
        step(0, 0, 16'h0, 1, 16'h0100, 0, 0, 0);
        idle(1);
        step(0, 1, 16'hFFFF, 0, 16'h0, 0, 0, 0);
        idle(2);
        step(0, 1, 16'h0020, 0, 16'h0, 0, 0, 0);
        step(0, 0, 16'h0, 0, 16'h0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 16'h0099, 1, 16'h0088, 1, 0, 0);
        step(0, 0, 16'h0, 0, 16'h0, 0, 1, 0);
        step(0, 0, 16'h0, 0, 16'h0, 0, 1, 0);
        step(0, 0, 16'h0, 0, 16'h0, 0, 0, 1);
        idle(2);

        // Async reset while a branch is being requested.
        bus.br_taken = 1'b1; bus.br_target = 16'h0077;
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        chk("async_reset_pc", bus.pc, 16'h0000);
        chk("async_reset_state", {14'd0, bus.state}, 16'h0000);
        chk("async_reset_flush", {14'd0, bus.flush_if_id, bus.flush_id_ex}, 16'h0000);
        @(posedge clk);
        #1;
        do_reset();

        halt_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            logic [15:0] btg, jt;
            btg = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                              : 16'($urandom);
            jt  = 16'($urandom);
            if (m_mode == 2) halt_cnt++;
            else halt_cnt = 0;
            if (halt_cnt > 6 && !(IRQ_ON && !m_inh)) begin
                do_reset();
                halt_cnt = 0;
            end else begin
                step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10, btg,
                     $urandom_range(0, 99) < 15, jt, $urandom_range(0, 99) < 4,
                     $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 6);
            end
        end

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Next-PC sequencer for the 5-stage pipeline. Each cycle it picks the fetch address (sequential, branch, jump, hold or interrupt vector), drives the PC register and flush signals for the IF/ID and ID/EX latches, and tracks a boot/run/halt state machine. It sits in the IF stage, between the hazard unit and branch logic (inputs) and the instruction memory and pipeline latches (outputs).

## Interface
- PC_W, 16, PC/address width
- RESET_VEC, 16'h0000, PC value at reset
- IRQ_VEC, 16'h0010, interrupt handler entry (used only with PC_SEQ_IRQ_EN)
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard-unit stall; hold PC
- br_taken  in  1  EX-stage branch resolved taken
- br_target  in  PC_W  branch target, valid with br_taken
- jmp  in  1  ID-stage unconditional jump
- jmp_target  in  PC_W  jump target, valid with jmp
- halt  in  1  ID-stage halt decoded
- pc  out  PC_W  registered fetch address
- npc  out  PC_W  pc+1, passed down the pipeline
- if_valid  out  1  current fetch slot holds a real instruction
- flush_if_id  out  1  squash IF/ID latch at next edge
- flush_id_ex  out  1  squash ID/EX latch at next edge
- state  out  2  FSM state (BOOT=0, RUN=1, HALT=2)
- irq, eret  in  1  interrupt request / return from handler (PC_SEQ_IRQ_EN only)
- irq_ack  out  1, epc  out  PC_W  (PC_SEQ_IRQ_EN only)

## Operation
- Reset (async): pc=RESET_VEC, npc=RESET_VEC+1, state=BOOT, if_valid=0, irq_ack=0, epc=0, in-handler flag=0.
- BOOT: one cycle; pc holds; all inputs ignored; flushes=0; -> RUN.
- RUN next-PC priority (highest first):
  1. br_taken: pc<=br_target; flush_if_id=1, flush_id_ex=1. Overrides stall, jmp and halt.
  2. jmp (and not stall): pc<=jmp_target; flush_if_id=1.
  3. stall: pc holds; no flush.
  4. halt (and not stall): pc holds; -> HALT.
  5. otherwise: pc<=pc+1.
- jmp or halt with stall: ignored this cycle; they are re-presented by ID once the stall drops.
- Arithmetic is modulo 2^PC_W: pc=16'hFFFF advances to 16'h0000. npc = pc+1, same wrap.
- HALT: pc holds, if_valid=0, flushes=0, all inputs ignored. Leave by reset only, or by irq (below).
- if_valid = 1 in RUN, 0 in BOOT/HALT.
- Reset asserted mid-operation, including during a redirect, forces the reset values immediately.

## Timing
- pc, state, epc and irq_ack are registered. Redirect targets appear on pc one edge after the request is sampled.
- flush_if_id and flush_id_ex are combinational from the current inputs and state. They are asserted in the same cycle as the causing request, so the pipeline squashes at that same edge.
- Branch penalty: 2 bubbles. Jump penalty: 1 bubble. Stall adds no bubble beyond its own length.
- npc updates together with pc.

## Configuration
- PC_SEQ_IRQ_EN defined:
  - In RUN, irq is taken when no br_taken, jmp or stall is asserted and the in-handler flag is 0. Taking it does epc<=pc, pc<=IRQ_VEC, flush_if_id=1, sets the in-handler flag, and pulses irq_ack high for one cycle.
  - In HALT, irq is taken the same way and state returns to RUN.
  - eret (RUN, not stall, no br_taken) does pc<=epc, flush_if_id=1 and clears the in-handler flag. It ranks with jmp; eret wins over jmp.
  - irq is ignored while the in-handler flag is set.
- PC_SEQ_IRQ_EN undefined: irq, eret, irq_ack and epc ports are absent, with no interrupt logic.

## Test plan
- Reset then 3 free-run cycles: pc 0000 (BOOT) -> 0000 -> 0001 -> 0002; if_valid 0 then 1; flushes 0.
- At pc=0005, br_taken=1, br_target=0040, with stall=1 and jmp=1: next pc=0040; flush_if_id=1 and flush_id_ex=1 in the request cycle.
- At pc=0010, jmp=1, jmp_target=0100 with stall=1 for 2 cycles, then jmp with stall=0: pc holds 0010 for 2 cycles, then 0100 with flush_if_id pulse only.
- pc=FFFF free-run: next pc=0000, npc=0001.
- halt at pc=0020: state=HALT, pc stays 0020 for 5 cycles, if_valid=0. With PC_SEQ_IRQ_EN, irq then gives pc=0010, epc=0020, irq_ack one pulse, state=RUN. A second irq is ignored. eret returns pc to 0020.
- Reset asserted mid-branch (br_taken high): pc=0000 and state=BOOT immediately, without waiting for a clock edge.
